countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_pkg.sv | 17 +
 rtl/countdown_bit.sv | 40 ++++
 rtl/countdown_timer.sv | 121 ++++++++++++
 tb/tb_countdown_timer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the countdown timer slice.
//   WIDTH_DEFAULT : default counter width in bits
//   state_t       : FSM state encoding (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package countdown_pkg;

   localparam int WIDTH_DEFAULT = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/countdown_bit.sv
// -----------------------------------------------------------------------------
// countdown_bit
// One bit of the down-counter.
// The cell holds a single register bit. A load takes priority over a
// decrement. A decrement toggles the bit when a borrow arrives from below.
// Ports:
//   clock      in  rising-edge clock
//   reset      in  synchronous active-low reset, clears the bit
//   ld         in  load strobe, selects ld_bit
//   ld_bit     in  value to load
//   dec        in  decrement qualifier for the whole counter
//   borrow_in  in  borrow from the next lower bit (1 for bit 0)
//   borrow_out out borrow to the next higher bit
//   q          out registered bit value
// -----------------------------------------------------------------------------
module countdown_bit (
   input  logic clock,
   input  logic reset,
   input  logic ld,
   input  logic ld_bit,
   input  logic dec,
   input  logic borrow_in,
   output logic borrow_out,
   output logic q
);

   // A borrow passes upward only through bits that are currently zero.
   assign borrow_out = borrow_in & ~q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         q <= 1'b0;
      end else if (ld) begin
         q <= ld_bit;
      end else if (dec) begin
         q <= q ^ borrow_in;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Loadable down-counter with an IDLE/RUN/DONE FSM. The counter emits a
// one-cycle done pulse when it reaches terminal count.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to enable auto-reload.
// With auto-reload, terminal count reloads the last non-zero load value
// and the timer stays in RUN.
// Ports:
//   clock      in  rising-edge clock
//   reset      in  synchronous active-low reset
//   enable     in  decrement qualifier
//   load       in  load load_value and start; has priority over enable
//   load_value in  [WIDTH] start value, unsigned
//   count      out [WIDTH] remaining count, registered
//   busy       out high while in RUN, registered
//   done       out one-cycle terminal-count pulse, registered
// -----------------------------------------------------------------------------
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   state_t           state;
   state_t           state_nx;
   logic             busy_nx;
   logic             done_nx;
   logic             reload_fire;
   logic             cell_ld;
   logic             cell_dec;
   logic             at_one;
   logic             load_zero;
   logic [WIDTH-1:0] cell_val;
   logic [WIDTH:0]   borrow;

   assign at_one    = (count == WIDTH'(1));
   assign load_zero = (load_value == '0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         reload_q <= '0;
      end else if (load && !load_zero) begin
         reload_q <= load_value;
      end
   end

   assign cell_val = load ? load_value : reload_q;
`else
   assign cell_val = load_value;
`endif

   // The final borrow-out is set only when every bit is zero. Gating the
   // decrement with it means the count can never wrap below zero.
   assign borrow[0] = 1'b1;
   assign cell_ld   = load | reload_fire;
   assign cell_dec  = (state == RUN) & enable & ~borrow[WIDTH];

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      countdown_bit u_bit (
         .clock      (clock),
         .reset      (reset),
         .ld         (cell_ld),
         .ld_bit     (cell_val[i]),
         .dec        (cell_dec),
         .borrow_in  (borrow[i]),
         .borrow_out (borrow[i+1]),
         .q          (count[i])
      );
   end

   always_comb begin
      state_nx    = state;
      done_nx     = 1'b0;
      reload_fire = 1'b0;
      if (load) begin
         state_nx = load_zero ? DONE : RUN;
         done_nx  = load_zero;
      end else begin
         case (state)
            RUN: begin
               if (enable && at_one) begin
                  done_nx = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  reload_fire = 1'b1;
`else
                  state_nx = DONE;
`endif
               end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = state;
         endcase
      end
      busy_nx = (state_nx == RUN);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Directed bench for countdown_timer (WIDTH = 6). Each stimulus cycle pushes
// the count/busy/done values expected after the next clock edge. A monitor
// process compares those values on the falling edge of that cycle.
// Defining COUNTDOWN_AUTO_RELOAD_EN switches terminal-count expectations to
// the auto-reload behaviour.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int W = 6;

  logic         clock      = 1'b0;
  logic         reset      = 1'b0;
  logic         enable     = 1'b0;
  logic         load       = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  always #5 clock = ~clock;

  countdown_timer #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] cnt;
    logic         bsy;
    logic         dn;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   compared   = 0;
  int   mismatched = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: sample outputs on the falling edge and check entries due now.
  initial begin
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        bit   bad;
        e = sb.pop_front();
        bad = 1'b0;
        compared++;
        if (e.cyc != cyc) begin
          bad = 1'b1;
          $display("FAIL %s: checked at cycle %0d, due %0d", e.name, cyc, e.cyc);
        end
        if (count !== e.cnt) begin
          bad = 1'b1;
          $display("FAIL %s: count=%0d want %0d (cycle %0d)", e.name, count, e.cnt, cyc);
        end
        if (busy !== e.bsy) begin
          bad = 1'b1;
          $display("FAIL %s: busy=%b want %b (cycle %0d)", e.name, busy, e.bsy, cyc);
        end
        if (done !== e.dn) begin
          bad = 1'b1;
          $display("FAIL %s: done=%b want %b (cycle %0d)", e.name, done, e.dn, cyc);
        end
        if (bad) mismatched++;
      end
    end
  end

  task automatic step(input logic rn, input logic ld, input logic en,
                      input logic [W-1:0] lv, input logic [W-1:0] ec,
                      input logic eb, input logic ed, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    reset      = rn;
    load       = ld;
    enable     = en;
    load_value = lv;
    e.cyc  = cyc + 1;
    e.cnt  = ec;
    e.bsy  = eb;
    e.dn   = ed;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Final enabled cycle at count=1 after a load of v. This leaves the timer
  // in IDLE with count 0 in both build variants.
  task automatic term(input logic [W-1:0] v, input string nm);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    step(1, 0, 1, 0, v, 1, 1, {nm, "_reload"});
    step(1, 1, 0, 0, 0, 0, 1, {nm, "_load0"});
    step(1, 0, 0, 0, 0, 0, 0, {nm, "_idle"});
`else
    step(1, 0, 1, 0, 0, 0, 1, {nm, "_term"});
    step(1, 0, 0, 0, 0, 0, 0, {nm, "_idle"});
`endif
  endtask

  initial begin
    // Reset for two cycles; enable alone must not move the count.
    step(0, 0, 0, 0, 0, 0, 0, "rst0");
    step(0, 1, 1, 9, 0, 0, 0, "rst1_over_load");
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0, 0, "idle_en");

    // Load 5 with enable held.
    step(1, 1, 1, 5, 5, 1, 0, "v5_load");
    step(1, 0, 1, 0, 4, 1, 0, "v5_4");
    step(1, 0, 1, 0, 3, 1, 0, "v5_3");
    step(1, 0, 1, 0, 2, 1, 0, "v5_2");
    step(1, 0, 1, 0, 1, 1, 0, "v5_1");
    term(5, "v5");
    step(1, 0, 1, 0, 0, 0, 0, "v5_idle_en");

    // Load 3 with enable toggling.
    step(1, 1, 0, 3, 3, 1, 0, "v3_load");
    step(1, 0, 1, 0, 2, 1, 0, "v3_en");
    step(1, 0, 0, 0, 2, 1, 0, "v3_hold");
    step(1, 0, 1, 0, 1, 1, 0, "v3_en2");
    step(1, 0, 0, 0, 1, 1, 0, "v3_hold2");
    term(3, "v3");

    // Load 63, restart with 2 at count 40.
    step(1, 1, 1, 63, 63, 1, 0, "v63_load");
    for (int i = 1; i <= 23; i++) step(1, 0, 1, 0, W'(63 - i), 1, 0, "v63_dec");
    step(1, 1, 1, 2, 2, 1, 0, "restart_2");
    step(1, 0, 1, 0, 1, 1, 0, "restart_1");
    term(2, "restart");

    // Load of zero goes straight to DONE and never raises busy.
    step(1, 1, 1, 0, 0, 0, 1, "load0");
    step(1, 0, 1, 0, 0, 0, 0, "load0_idle");
    step(1, 0, 0, 0, 0, 0, 0, "load0_idle2");

    // Load zero during RUN aborts to DONE.
    step(1, 1, 0, 4, 4, 1, 0, "abort_load");
    step(1, 0, 1, 0, 3, 1, 0, "abort_3");
    step(1, 1, 1, 0, 0, 0, 1, "abort_load0");
    step(1, 0, 0, 0, 0, 0, 0, "abort_idle");

    // Hold while enable is low.
    step(1, 1, 0, 7, 7, 1, 0, "hold_load");
    step(1, 0, 0, 0, 7, 1, 0, "hold_a");
    step(1, 0, 0, 0, 7, 1, 0, "hold_b");

    // Reset mid-run: no done pulse, IDLE afterwards.
    step(1, 1, 1, 4, 4, 1, 0, "mid_load");
    step(1, 0, 1, 0, 3, 1, 0, "mid_3");
    step(1, 0, 1, 0, 2, 1, 0, "mid_2");
    step(0, 0, 1, 0, 0, 0, 0, "mid_rst");
    step(1, 0, 1, 0, 0, 0, 0, "mid_post");
    step(1, 0, 1, 0, 0, 0, 0, "mid_post2");

    // Load 2 with enable held: reload sequence or one-shot.
    step(1, 1, 1, 2, 2, 1, 0, "ar_load");
    step(1, 0, 1, 0, 1, 1, 0, "ar_1");
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    step(1, 0, 1, 0, 2, 1, 1, "ar_reload1");
    step(1, 0, 1, 0, 1, 1, 0, "ar_1b");
    step(1, 0, 1, 0, 2, 1, 1, "ar_reload2");
    step(1, 1, 1, 0, 0, 0, 1, "ar_load0");
    step(1, 0, 1, 0, 0, 0, 0, "ar_idle");
`else
    step(1, 0, 1, 0, 0, 0, 1, "os_term");
    step(1, 0, 1, 0, 0, 0, 0, "os_idle");
    step(1, 1, 1, 1, 1, 1, 0, "os_v1_load");
    step(1, 0, 1, 0, 0, 0, 1, "os_v1_term");
    step(1, 0, 1, 0, 0, 0, 0, "os_v1_idle");
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      compared++;
      mismatched++;
      $display("FAIL %s: never checked, want count=%0d busy=%b done=%b",
               e.name, e.cnt, e.bsy, e.dn);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, compared=%0d", compared);
    $fatal(1, "timeout");
  end

endmodule
